// File: rtl/hourglass_pkg.sv
// Shared definitions for the hourglass timer.
//   state_t   : FSM state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3)
//   NUM_W     : width of the seconds counter / display value
//   flip_num  : seconds remaining after the glass is turned over
package hourglass_pkg;

  localparam int NUM_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Turning the glass over swaps the chambers: what was in the bottom
  // (full - cur) is now on top. cur never exceeds full in normal
  // operation, but clamp so the result can never wrap around.
  function automatic logic [NUM_W-1:0] flip_num(input logic [NUM_W-1:0] full,
                                                input logic [NUM_W-1:0] cur);
    return (cur > full) ? '0 : full - cur;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus counting debouncer with a registered edge pulse.
//   clk, rst : system clock, synchronous active-high reset
//   raw      : asynchronous, bouncy input level
//   ev       : one-cycle pulse when the debounced level changes
//              (rising edge only, or any edge when ANY_EDGE=1)
// The debounced level adopts the synchronised level on the DEB_CYCLES-th
// consecutive cycle that the two differ; any agreeing cycle clears the count.
module key_debounce #(
  parameter int DEB_CYCLES = 20,
  parameter bit ANY_EDGE   = 1'b0,
  parameter bit RST_TO_RAW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic ev
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;
  logic          rst_level;

  // A level input (tilt switch) must come out of reset already agreeing
  // with the switch position, otherwise the first debounce would look like
  // a flip. The synchroniser is preloaded too so it cannot disagree.
  assign rst_level = RST_TO_RAW ? raw : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= rst_level;
      sync2 <= rst_level;
      level <= rst_level;
      cnt   <= '0;
      ev    <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      ev    <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
          ev    <= ANY_EDGE ? 1'b1 : sync2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/hourglass_timer.sv
// Time base and control core of the electronic hourglass.
//   clk       : system clock (CLK_HZ cycles per sand-second)
//   rst       : synchronous active-high reset, aborts any run
//   key_start : raw start/pause button (debounced here, rising edge = start_ev)
//   tilt      : raw tilt switch level (debounced here, any edge = flip_ev)
//   num       : seconds remaining in the top chamber, 0..SEC_MAX
//   sec_tick  : one-cycle pulse per counted second while running
//   running   : high while in RUN
//   done      : high while in DONE
// All outputs are registered. Events are registered by the debouncers and
// acted on by the FSM one cycle later. A flip always beats a start press and
// beats the prescaler wrap in the same cycle.
module hourglass_timer
  import hourglass_pkg::*;
#(
  parameter int CLK_HZ     = 1000,
  parameter int SEC_MAX    = 60,
  parameter int DEB_CYCLES = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             tilt,
  output logic [NUM_W-1:0] num,
  output logic             sec_tick,
  output logic             running,
  output logic             done
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [NUM_W-1:0] SEC_FULL   = NUM_W'(SEC_MAX);

  logic start_ev;
  logic flip_ev;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .ANY_EDGE  (1'b0),
    .RST_TO_RAW(1'b0)
  ) u_key_deb (
    .clk(clk),
    .rst(rst),
    .raw(key_start),
    .ev (start_ev)
  );

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .ANY_EDGE  (1'b1),
    .RST_TO_RAW(1'b1)
  ) u_tilt_deb (
    .clk(clk),
    .rst(rst),
    .raw(tilt),
    .ev (flip_ev)
  );

  state_t           state;
  state_t           state_n;
  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_n;
  logic [NUM_W-1:0] num_n;
  logic             tick_n;
  logic             running_n;
  logic             done_n;

  // State register, seconds counter, prescaler and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      num      <= SEC_FULL;
      presc    <= '0;
      sec_tick <= 1'b0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      num      <= num_n;
      presc    <= presc_n;
      sec_tick <= tick_n;
      running  <= running_n;
      done     <= done_n;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_n = state;
    num_n   = num;
    presc_n = presc;
    tick_n  = 1'b0;
    if (flip_ev && (state != ST_IDLE)) begin
      // Flip takes priority over start and over the second wrap. Flipping a
      // full glass empties the top at once, so go straight to DONE.
      num_n   = flip_num(SEC_FULL, num);
      presc_n = '0;
      state_n = (num_n == '0) ? ST_DONE : ST_RUN;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ev) begin
            state_n = ST_RUN;
            presc_n = '0;
          end
        end
        ST_RUN: begin
          if (start_ev) begin
            state_n = ST_PAUSE;
          end else if (presc == PRESC_LAST) begin
            presc_n = '0;
            if (num != '0) begin
              tick_n = 1'b1;
              num_n  = num - NUM_W'(1);
              if (num == NUM_W'(1)) state_n = ST_DONE;
            end
          end else begin
            presc_n = presc + PW'(1);
          end
        end
        ST_PAUSE: begin
          // Prescaler is held, so the partial second resumes where it left off.
          if (start_ev) state_n = ST_RUN;
        end
        ST_DONE: begin
          if (start_ev) begin
            state_n = ST_IDLE;
            num_n   = SEC_FULL;
            presc_n = '0;
          end
        end
      endcase
    end
  end

  // Output decode from the next state so the status flags line up with state.
  always_comb begin
    running_n = (state_n == ST_RUN);
    done_n    = (state_n == ST_DONE);
  end

endmodule
